// File: rtl/pacman_pkg.sv
// Shared types, keycode constants and helpers for the Pac-Man direction controller.
package pacman_pkg;

    localparam int unsigned KEY_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DIR_W  = 2;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_MOVING  = 1'b1
    } state_t;

    // HID usage codes: WASD letters and the arrow cluster
    localparam logic [KEY_W-1:0] HID_W           = 8'h1A;
    localparam logic [KEY_W-1:0] HID_S           = 8'h16;
    localparam logic [KEY_W-1:0] HID_A           = 8'h04;
    localparam logic [KEY_W-1:0] HID_D           = 8'h07;
    localparam logic [KEY_W-1:0] HID_ARROW_UP    = 8'h52;
    localparam logic [KEY_W-1:0] HID_ARROW_DOWN  = 8'h51;
    localparam logic [KEY_W-1:0] HID_ARROW_LEFT  = 8'h50;
    localparam logic [KEY_W-1:0] HID_ARROW_RIGHT = 8'h4F;

    // Opposite direction: the encoding pairs up/down and left/right on bit 0
    function automatic dir_t reverse(input dir_t d);
        return dir_t'(DIR_W'(d) ^ DIR_W'(1));
    endfunction

endpackage

// File: rtl/pacman_key_decode.sv
// Registers the keycode, decodes it to a direction and flags new key presses.
module pacman_key_decode
    import pacman_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_UP    = HID_W,
    parameter logic [KEY_W-1:0] KEY_DOWN  = HID_S,
    parameter logic [KEY_W-1:0] KEY_LEFT  = HID_A,
    parameter logic [KEY_W-1:0] KEY_RIGHT = HID_D,
    parameter bit               ARROWS_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] keycode,
    output logic             key_valid_c,
    output dir_t             key_dir_c,
    output logic             key_event
);

    logic [KEY_W-1:0] keycode_q;
    logic [KEY_W-1:0] keycode_prev;

    // Input capture plus one-deep history for change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            keycode_q    <= '0;
            keycode_prev <= '0;
            key_event    <= 1'b0;
        end else begin
            keycode_q    <= keycode;
            keycode_prev <= keycode_q;
            key_event    <= key_valid_c && (keycode_q != keycode_prev);
        end
    end

    // Map the captured keycode to a direction; anything unrecognised is ignored
    always_comb begin
        key_valid_c = 1'b0;
        key_dir_c   = DIR_UP;
        if (keycode_q == KEY_UP || (ARROWS_EN && keycode_q == HID_ARROW_UP)) begin
            key_valid_c = 1'b1;
            key_dir_c   = DIR_UP;
        end else if (keycode_q == KEY_DOWN || (ARROWS_EN && keycode_q == HID_ARROW_DOWN)) begin
            key_valid_c = 1'b1;
            key_dir_c   = DIR_DOWN;
        end else if (keycode_q == KEY_LEFT || (ARROWS_EN && keycode_q == HID_ARROW_LEFT)) begin
            key_valid_c = 1'b1;
            key_dir_c   = DIR_LEFT;
        end else if (keycode_q == KEY_RIGHT || (ARROWS_EN && keycode_q == HID_ARROW_RIGHT)) begin
            key_valid_c = 1'b1;
            key_dir_c   = DIR_RIGHT;
        end
    end

endmodule

// File: rtl/pacman_dir_ctrl.sv
// Pac-Man direction controller: buffers turn requests and applies them at tile centres.
module pacman_dir_ctrl
    import pacman_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_UP      = HID_W,
    parameter logic [KEY_W-1:0] KEY_DOWN    = HID_S,
    parameter logic [KEY_W-1:0] KEY_LEFT    = HID_A,
    parameter logic [KEY_W-1:0] KEY_RIGHT   = HID_D,
    parameter bit               ARROWS_EN   = 1'b1,
    parameter int unsigned      PEND_FRAMES = 8,
    parameter logic [DIR_W-1:0] RESET_DIR   = 2'd2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  keycode,
    input  logic              frame_tick,
    input  logic              tile_aligned,
    input  logic [MASK_W-1:0] blocked,
    output logic [DIR_W-1:0]  dir,
    output logic              moving,
    output logic              pend_valid,
    output logic [DIR_W-1:0]  pend_dir,
    output logic              key_event
);

    logic             key_valid_c;
    dir_t             key_dir_c;

    state_t           state_q, state_n;
    dir_t             dir_q, dir_n;
    logic             pend_valid_q, pend_valid_n;
    dir_t             pend_dir_q, pend_dir_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic             reversal_c;
    logic             eval_c;
    logic             eff_pend_valid_c;
    dir_t             eff_pend_dir_c;

    pacman_key_decode #(
        .KEY_UP    (KEY_UP),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT),
        .ARROWS_EN (ARROWS_EN)
    ) u_key_decode (
        .clk         (clk),
        .reset       (reset),
        .keycode     (keycode),
        .key_valid_c (key_valid_c),
        .key_dir_c   (key_dir_c),
        .key_event   (key_event)
    );

    // State, direction and turn-buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_STOPPED;
            dir_q        <= dir_t'(RESET_DIR);
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_n;
            dir_q        <= dir_n;
            pend_valid_q <= pend_valid_n;
            pend_dir_q   <= pend_dir_n;
            cnt_q        <= cnt_n;
        end
    end

    // A key arriving on the same cycle as a tick is seen by that tick's evaluation
    assign eff_pend_valid_c = key_valid_c ? 1'b1 : pend_valid_q;
    assign eff_pend_dir_c   = key_valid_c ? key_dir_c : pend_dir_q;
    assign reversal_c       = key_event && key_valid_c && (key_dir_c == reverse(dir_q));
    assign eval_c           = frame_tick && tile_aligned;

    // Next-state: buffer refresh/expiry, then reversal, then tile-centre evaluation
    always_comb begin
        state_n      = state_q;
        dir_n        = dir_q;
        pend_valid_n = pend_valid_q;
        pend_dir_n   = pend_dir_q;
        cnt_n        = cnt_q;

        if (key_valid_c) begin
            pend_dir_n   = key_dir_c;
            pend_valid_n = 1'b1;
            cnt_n        = CNT_W'(PEND_FRAMES);
        end else if (frame_tick && (cnt_q != '0)) begin
            cnt_n = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                pend_valid_n = 1'b0;
            end
        end

        if (reversal_c) begin
            dir_n        = key_dir_c;
            pend_valid_n = 1'b0;
            if (!blocked[key_dir_c]) begin
                state_n = ST_MOVING;
            end
        end else if (eval_c) begin
            if (eff_pend_valid_c && !blocked[eff_pend_dir_c]) begin
                dir_n        = eff_pend_dir_c;
                pend_valid_n = 1'b0;
                state_n      = ST_MOVING;
            end else if (blocked[dir_q]) begin
                state_n = ST_STOPPED;
            end else begin
                state_n = ST_MOVING;
            end
        end
    end

    assign dir        = dir_q;
    assign moving     = (state_q == ST_MOVING);
    assign pend_valid = pend_valid_q;
    assign pend_dir   = pend_dir_q;

endmodule
